// File: rtl/apple_placement_controller_pkg.sv
// Shared geometry and segment-field constants for the snake playfield.
// The apple and the snake body both live on this grid.
package apple_placement_controller_pkg;

  localparam int MaxSegments     = 128;
  localparam int BorderThickness = 10;
  localparam int AppleWidth      = 10;
  localparam int AppleHeight     = 10;
  localparam int DisplayWidth    = 240;
  localparam int DisplayHeight   = 320;
  localparam int Cols = (DisplayWidth - 2 * BorderThickness) / AppleWidth;
  localparam int Rows = (DisplayHeight - 2 * BorderThickness) / AppleHeight;

  localparam int SegXWidth = 8;
  localparam int SegYWidth = 9;
  localparam int IdxWidth  = $clog2(MaxSegments);

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/apple_placement_controller_lfsr16.sv
// Free-running 16-bit LFSR; runs every clock so request timing adds entropy.
module apple_lfsr16
  import apple_placement_controller_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge clock) begin
    if (reset) lfsr <= Seed;
    else       lfsr <= lfsrNext(lfsr);
  end

endmodule

// File: rtl/apple_placement_controller.sv
// Picks a free grid cell for the next apple by drawing LFSR candidates and
// scanning the snake body one segment per clock.
//
// state      | meaning
// StIdle     | waiting for placeReq
// StGen      | draw candidate; out-of-grid draws are rejected and redrawn
// StScan     | compare candidate with segment idx
// StDoneOk   | commit candidate, pulse placed
// StDoneFail | retries exhausted, keep old apple, pulse placeFail
module apple_placement_controller
  import apple_placement_controller_pkg::*;
#(
  parameter int          InitAppleX = 120,
  parameter int          InitAppleY = 160,
  parameter logic [15:0] LfsrSeed   = 16'hACE1,
  parameter int          MaxRetries = 255
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               placeReq,
  input  logic [MaxSegments*SegXWidth-1:0]   snakeLocX,
  input  logic [MaxSegments*SegYWidth-1:0]   snakeLocY,
  input  logic [7:0]                         size,
  output logic [SegXWidth-1:0]               appleLocX,
  output logic [SegYWidth-1:0]               appleLocY,
  output logic                               busy,
  output logic                               placed,
  output logic                               placeFail
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StGen      = 3'd1;
  localparam logic [2:0] StScan     = 3'd2;
  localparam logic [2:0] StDoneOk   = 3'd3;
  localparam logic [2:0] StDoneFail = 3'd4;

  logic [2:0]           state;
  logic [15:0]          lfsr;
  logic [7:0]           sizeQ;
  logic [IdxWidth-1:0]  idx;
  logic [15:0]          retry;
  logic [SegXWidth-1:0] candX;
  logic [SegYWidth-1:0] candY;
  logic [4:0]           col;
  logic [4:0]           row;
  logic                 candValid;
  logic [SegXWidth-1:0] segX;
  logic [SegYWidth-1:0] segY;
  logic                 segHit;
  logic                 lastIdx;
  logic                 unusedLfsrBits;

  apple_lfsr16 #(.Seed(LfsrSeed)) uLfsr (
    .clock(clock),
    .reset(reset),
    .lfsr (lfsr)
  );

  assign col            = lfsr[4:0];
  assign row            = lfsr[9:5];
  assign unusedLfsrBits = ^lfsr[15:10];
  assign candValid      = (int'(col) < Cols) && (int'(row) < Rows);

  assign segX    = snakeLocX[int'(idx)*SegXWidth +: SegXWidth];
  assign segY    = snakeLocY[int'(idx)*SegYWidth +: SegYWidth];
  assign segHit  = (segX == candX) && (segY == candY);
  assign lastIdx = ({1'b0, idx} == sizeQ - 8'd1);

  assign placed    = (state == StDoneOk);
  assign placeFail = (state == StDoneFail);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= StIdle;
      appleLocX <= SegXWidth'(InitAppleX);
      appleLocY <= SegYWidth'(InitAppleY);
      busy      <= 1'b0;
      sizeQ     <= 8'd0;
      idx       <= '0;
      retry     <= 16'd0;
      candX     <= '0;
      candY     <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (placeReq) begin
            sizeQ <= (size > 8'(MaxSegments)) ? 8'(MaxSegments) : size;
            retry <= 16'd0;
            busy  <= 1'b1;
            state <= StGen;
          end
        end
        StGen: begin
          if (candValid) begin
            // Pixel math is done in 10 bits, then truncated to the field widths.
            candX <= SegXWidth'(10'(BorderThickness) + 10'(col) * 10'(AppleWidth));
            candY <= SegYWidth'(10'(BorderThickness) + 10'(row) * 10'(AppleHeight));
            idx   <= '0;
            state <= (sizeQ == 8'd0) ? StDoneOk : StScan;
          end
        end
        StScan: begin
          if (segHit) begin
            if (retry == 16'(MaxRetries - 1)) begin
              state <= StDoneFail;
            end else begin
              retry <= retry + 16'd1;
              state <= StGen;
            end
          end else if (lastIdx) begin
            state <= StDoneOk;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        StDoneOk: begin
          appleLocX <= candX;
          appleLocY <= candY;
          busy      <= 1'b0;
          state     <= StIdle;
        end
        StDoneFail: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
